// File: rtl/encap_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : encap_arbiter                                                |
// | Description : Round-robin arbiter/sequencer sharing one encapsulator       |
// |               between NUM_REQ DFX sources. Issues a one-cycle grant,       |
// |               follows the encapsulator busy/valid handshake through the    |
// |               packet serialisation and returns per-requester ack/done.     |
// | Option      : ENCAP_TIMEOUT_EN - adds a watchdog on the busy phase that    |
// |               aborts a stuck transfer after TIMEOUT_CYCLES cycles.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk, rst          clock, synchronous active-high reset                   |
// |   req_valid         per-requester request, held until its req_ack          |
// |   req_data          flattened payloads, DATA_DFX_WIDTH bits per requester  |
// |   req_header        flattened headers, HEADER_WIDTH bits per requester     |
// |   req_ack/req_done  one-hot single-cycle pulses towards the owner          |
// |   encap_ready       encapsulator idle/ready                                |
// |   encap_valid       encapsulator output beat strobe                        |
// |   arbiter_gnt       single-cycle grant to the encapsulator                 |
// |   data_dfx_send     registered selected payload                            |
// |   header_pkt_send   registered selected header                             |
// |   busy, owner       status: non-idle, current/last granted requester       |
// |   err_beat          sticky: transfer ended with wrong beat count           |
// |   err_timeout       sticky: watchdog expired (0 without the option)        |
// +----------------------------------------------------------------------------+
module encap_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_DFX_WIDTH = 1034,
  parameter int HEADER_WIDTH   = 9,
  parameter int NUMBER_PACKET  = 19,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ*DATA_DFX_WIDTH-1:0]  req_data,
  input  logic [NUM_REQ*HEADER_WIDTH-1:0]    req_header,
  output logic [NUM_REQ-1:0]                 req_ack,
  output logic [NUM_REQ-1:0]                 req_done,
  input  logic                               encap_ready,
  input  logic                               encap_valid,
  output logic                               arbiter_gnt,
  output logic [DATA_DFX_WIDTH-1:0]          data_dfx_send,
  output logic [HEADER_WIDTH-1:0]            header_pkt_send,
  output logic                               busy,
  output logic [$clog2(NUM_REQ)-1:0]         owner,
  output logic                               err_beat,
  output logic                               err_timeout
);

  localparam int IW = $clog2(NUM_REQ);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] GRANT     = 2'd1;
  localparam logic [1:0] WAIT_BUSY = 2'd2;
  localparam logic [1:0] WAIT_DONE = 2'd3;

  logic [1:0]                state_q, state_d;
  logic [IW-1:0]             ptr_q, ptr_d;
  logic [IW-1:0]             owner_q, owner_d;
  logic [DATA_DFX_WIDTH-1:0] data_q, data_d;
  logic [HEADER_WIDTH-1:0]   hdr_q, hdr_d;
  logic [4:0]                beat_q, beat_d;
  logic [NUM_REQ-1:0]        done_q, done_d;
  logic                      err_beat_q, err_beat_d;

  logic                      w_sel_found;
  logic [IW-1:0]             w_sel_idx;
  logic [IW:0]               w_sum;
  logic [4:0]                w_beat_inc;
  logic                      w_timeout;

  // Cyclic search starting at the round-robin pointer; one extra bit on the
  // sum keeps the wrap test exact for non-power-of-two NUM_REQ.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    w_sum       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, ptr_q} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(NUM_REQ)) begin
        w_sum = w_sum - (IW+1)'(NUM_REQ);
      end
      if (!w_sel_found && req_valid[w_sum[IW-1:0]]) begin
        w_sel_found = 1'b1;
        w_sel_idx   = w_sum[IW-1:0];
      end
    end
  end

  // Beat count including the current cycle, saturating at 31.
  assign w_beat_inc = (encap_valid && (beat_q != 5'd31)) ? beat_q + 5'd1 : beat_q;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    data_d     = data_q;
    hdr_d      = hdr_q;
    beat_d     = beat_q;
    done_d     = '0;
    err_beat_d = err_beat_q;
    case (state_q)
      IDLE: begin
        if (encap_ready && w_sel_found) begin
          owner_d = w_sel_idx;
          data_d  = req_data[int'(w_sel_idx)*DATA_DFX_WIDTH +: DATA_DFX_WIDTH];
          hdr_d   = req_header[int'(w_sel_idx)*HEADER_WIDTH +: HEADER_WIDTH];
          state_d = GRANT;
        end
      end
      GRANT: begin
        ptr_d   = (owner_q == IW'(NUM_REQ-1)) ? '0 : owner_q + IW'(1);
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!encap_ready) begin
          beat_d  = '0;
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        beat_d = w_beat_inc;
        if (encap_ready) begin
          done_d[owner_q] = 1'b1;
          if (w_beat_inc != 5'(NUMBER_PACKET)) begin
            err_beat_d = 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Watchdog abort overrides the normal handshake.
    if (w_timeout) begin
      done_d          = '0;
      done_d[owner_q] = 1'b1;
      state_d         = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      data_q     <= '0;
      hdr_q      <= '0;
      beat_q     <= '0;
      done_q     <= '0;
      err_beat_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      data_q     <= data_d;
      hdr_q      <= hdr_d;
      beat_q     <= beat_d;
      done_q     <= done_d;
      err_beat_q <= err_beat_d;
    end
  end

`ifdef ENCAP_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmr_q;
  logic          err_to_q;

  // tmr_q counts elapsed busy cycles; the last one is TIMEOUT_CYCLES-1.
  assign w_timeout = ((state_q == WAIT_BUSY) || (state_q == WAIT_DONE)) &&
                     (tmr_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tmr_q    <= '0;
      err_to_q <= 1'b0;
    end else begin
      if (state_q == GRANT) begin
        tmr_q <= '0;
      end else if ((state_q == WAIT_BUSY) || (state_q == WAIT_DONE)) begin
        tmr_q <= tmr_q + TW'(1);
      end
      if (w_timeout) begin
        err_to_q <= 1'b1;
      end
    end
  end

  assign err_timeout = err_to_q;
`else
  logic [31:0] w_unused_timeout;
  assign w_unused_timeout = 32'(TIMEOUT_CYCLES);
  assign w_timeout        = 1'b0;
  assign err_timeout      = 1'b0;
`endif

  always_comb begin
    req_ack = '0;
    if (state_q == GRANT) begin
      req_ack[owner_q] = 1'b1;
    end
  end

  assign arbiter_gnt     = (state_q == GRANT);
  assign busy            = (state_q != IDLE);
  assign owner           = owner_q;
  assign data_dfx_send   = data_q;
  assign header_pkt_send = hdr_q;
  assign req_done        = done_q;
  assign err_beat        = err_beat_q;

endmodule
`default_nettype wire

// File: tb/tb_encap_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_encap_arbiter                                             |
// | Description : Self-checking bench for encap_arbiter: directed vector       |
// |               table, corner-case sequences and randomized traffic against  |
// |               a round-robin reference model and an encapsulator model.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_encap_arbiter;
  localparam int N  = 4;
  localparam int DW = 1034;
  localparam int HW = 9;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N*HW-1:0] req_header;
  logic [N-1:0]    req_ack, req_done;
  logic            encap_ready, encap_valid;
  logic            arbiter_gnt, busy, err_beat, err_timeout;
  logic [DW-1:0]   data_dfx_send;
  logic [HW-1:0]   header_pkt_send;
  logic [1:0]      owner;

  always #5 clk = ~clk;

  encap_arbiter #(.NUM_REQ(N), .DATA_DFX_WIDTH(DW), .HEADER_WIDTH(HW),
                  .NUMBER_PACKET(19), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_header(req_header), .req_ack(req_ack), .req_done(req_done),
    .encap_ready(encap_ready), .encap_valid(encap_valid),
    .arbiter_gnt(arbiter_gnt), .data_dfx_send(data_dfx_send),
    .header_pkt_send(header_pkt_send), .busy(busy), .owner(owner),
    .err_beat(err_beat), .err_timeout(err_timeout)
  );

  int checks   = 0;
  int failures = 0;

  // Encapsulator model state
  int em_phase = 0;
  int em_left  = 0;
  int em_beats = 19;
  bit em_stuck = 1'b0;
  bit em_hold_low = 1'b0;

  typedef struct {
    logic [N-1:0] mask;
    int           beats;
    int           exp_owner;
    logic         exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_data(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual(low64)=%0h required(low64)=%0h", name, act[63:0], exp[63:0]);
    end
  endtask

  // One clock; DUT outputs are sampled and the encapsulator model advanced
  // 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (rst) begin
      em_phase    = 0;
      encap_ready = 1'b1;
      encap_valid = 1'b0;
    end else begin
      case (em_phase)
        0: begin
          encap_valid = 1'b0;
          encap_ready = !em_hold_low;
          if (arbiter_gnt) begin
            encap_ready = 1'b0;
            em_phase    = 1;
          end
        end
        1: begin
          if (!em_stuck) begin
            em_left  = em_beats;
            em_phase = 2;
          end
        end
        default: begin
          if (em_left > 0) begin
            encap_valid = 1'b1;
            em_left--;
          end else begin
            encap_valid = 1'b0;
            encap_ready = 1'b1;
            em_phase    = 0;
          end
        end
      endcase
    end
  endtask

  task automatic rand_payload(input logic [N-1:0] mask);
    logic [DW-1:0] tmp;
    tmp = '0;
    for (int i = 0; i < N; i++) begin
      if (mask[i]) begin
        for (int w = 0; w < (DW + 31) / 32; w++) tmp = {tmp[DW-33:0], 32'($urandom())};
        req_data[i*DW +: DW]   = tmp;
        req_header[i*HW +: HW] = HW'($urandom());
      end
    end
  endtask

  task automatic do_reset();
    req_valid   = '0;
    em_stuck    = 1'b0;
    em_hold_low = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  // mode: 0 keep requests, 1 drop all after grant, 2 drop only the owner
  task automatic run_xfer(input logic [N-1:0] mask, input int beats, input int exp_owner,
                          input logic exp_err, input int mode);
    int n, extra, busy_lo;
    logic [N-1:0] exp1h;
    exp1h     = N'(1) << exp_owner;
    req_valid = mask;
    em_beats  = beats;
    n = 0;
    while (!arbiter_gnt && n < 10) begin
      step();
      n++;
    end
    chk("gnt_seen", 64'(arbiter_gnt), 64'(1));
    if (!arbiter_gnt) return;
    chk("owner", 64'(owner), 64'(exp_owner));
    chk("ack_onehot", 64'(req_ack), 64'(exp1h));
    chk("done_idle_at_gnt", 64'(req_done), 64'(0));
    chk("busy_at_gnt", 64'(busy), 64'(1));
    chk_data("data_slice", data_dfx_send, req_data[exp_owner*DW +: DW]);
    chk("header_slice", 64'(header_pkt_send), 64'(req_header[exp_owner*HW +: HW]));
    case (mode)
      1: req_valid = '0;
      2: req_valid[exp_owner] = 1'b0;
      default: ;
    endcase
    extra = 0;
    busy_lo = 0;
    n = 0;
    do begin
      step();
      n++;
      if (arbiter_gnt) extra++;
      if (!busy && req_done == '0) busy_lo++;
    end while (req_done == '0 && n < 80);
    chk("done_onehot", 64'(req_done), 64'(exp1h));
    chk("done_latency", 64'(n), 64'(beats + 3));
    chk("extra_gnt", 64'(extra), 64'(0));
    chk("busy_through", 64'(busy_lo), 64'(0));
    chk("err_beat", 64'(err_beat), 64'(exp_err));
  endtask

  // Reference round-robin choice from the rule "first set bit from pointer up, wrapping".
  function automatic int rr_pick(input logic [N-1:0] m, input int p);
    for (int k = 0; k < N; k++) begin
      if (m[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  vec_t vecs[9];

  initial begin
    int seq[5];
    int dones, mptr, eo, bt;
    logic eerr;

    rst = 1'b1; req_valid = '0; req_data = '0; req_header = '0;
    encap_ready = 1'b1; encap_valid = 1'b0;
    step();
    step();
    chk("rst_gnt", 64'(arbiter_gnt), 64'(0));
    chk("rst_ack_done", 64'({req_ack, req_done}), 64'(0));
    chk("rst_busy_owner", 64'({busy, owner}), 64'(0));
    chk("rst_errs", 64'({err_beat, err_timeout}), 64'(0));
    chk_data("rst_data", data_dfx_send, '0);
    chk("rst_header", 64'(header_pkt_send), 64'(0));
    rst = 1'b0;
    step();

    // Directed vector table, applied in order from reset (pointer starts at 0)
    vecs[0] = '{4'b0001, 19, 0, 1'b0};
    vecs[1] = '{4'b1111, 19, 1, 1'b0};
    vecs[2] = '{4'b1001, 19, 3, 1'b0};
    vecs[3] = '{4'b1001, 19, 0, 1'b0};
    vecs[4] = '{4'b0100, 19, 2, 1'b0};
    vecs[5] = '{4'b0011, 19, 0, 1'b0};
    vecs[6] = '{4'b1110, 19, 1, 1'b0};
    vecs[7] = '{4'b0010, 18, 1, 1'b1};
    vecs[8] = '{4'b0001, 19, 0, 1'b1};
    for (int v = 0; v < 9; v++) begin
      rand_payload(vecs[v].mask);
      run_xfer(vecs[v].mask, vecs[v].beats, vecs[v].exp_owner, vecs[v].exp_err, 1);
    end
    do_reset();
    chk("err_beat_cleared_by_rst", 64'(err_beat), 64'(0));

    // encap_ready held low in IDLE blocks the grant
    em_hold_low = 1'b1;
    encap_ready = 1'b0;
    rand_payload(4'b0010);
    req_valid = 4'b0010;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (arbiter_gnt || busy) dones++;
    end
    chk("no_gnt_while_not_ready", 64'(dones), 64'(0));
    em_hold_low = 1'b0;
    encap_ready = 1'b1;
    step();
    chk("gnt_after_ready", 64'(arbiter_gnt), 64'(1));
    run_xfer(4'b0010, 19, 1, 1'b0, 1);

    // All four requesting continuously: 0,1,2,3,0
    do_reset();
    seq = '{0, 1, 2, 3, 0};
    rand_payload(4'b1111);
    for (int i = 0; i < 5; i++) run_xfer(4'b1111, 19, seq[i], 1'b0, 0);

    // Reset in the middle of a transfer
    do_reset();
    rand_payload(4'b0001);
    req_valid = 4'b0001;
    step();
    chk("midrst_gnt", 64'(arbiter_gnt), 64'(1));
    req_valid = '0;
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1;
    step();
    chk("midrst_idle", 64'({busy, arbiter_gnt, req_done}), 64'(0));
    rst = 1'b0;
    step();
    chk("midrst_no_done", 64'({busy, req_done}), 64'(0));

    // encap_ready stuck low after the grant
    do_reset();
    em_stuck = 1'b1;
    rand_payload(4'b0100);
    req_valid = 4'b0100;
    step();
    chk("stuck_gnt_owner", 64'({arbiter_gnt, owner}), 64'({1'b1, 2'd2}));
    req_valid = '0;
    dones = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (req_done == 4'b0100) dones++;
      else if (req_done != '0) dones += 100;
    end
`ifdef ENCAP_TIMEOUT_EN
    chk("timeout_flag", 64'(err_timeout), 64'(1));
    chk("timeout_done", 64'(dones), 64'(1));
    chk("timeout_idle", 64'(busy), 64'(0));
`else
    chk("stuck_busy", 64'(busy), 64'(1));
    chk("stuck_no_timeout", 64'(err_timeout), 64'(0));
    chk("stuck_no_done", 64'(dones), 64'(0));
`endif

    // Randomized traffic against the round-robin reference
    do_reset();
    mptr = 0;
    eerr = 1'b0;
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(1) == 1) begin
          rand_payload(N'(1) << i);
          req_valid[i] = 1'b1;
        end
      end
      if (req_valid == '0) begin
        eo = $urandom_range(N - 1);
        rand_payload(N'(1) << eo);
        req_valid[eo] = 1'b1;
      end
      eo = $urandom_range(N - 1);
      if (req_valid[eo] && $countones(req_valid) > 1 && $urandom_range(3) == 0) req_valid[eo] = 1'b0;
      bt = ($urandom_range(3) == 0) ? 17 + $urandom_range(4) : 19;
      eerr = eerr | (bt != 19);
      eo = rr_pick(req_valid, mptr);
      run_xfer(req_valid, bt, eo, eerr, 2);
      mptr = (eo + 1) % N;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
